motor_pwm_driver: RTL and testbench

Differential-drive PWM back end for the rover motion path. Consumes the ramped `speed_o`/`dir_o` pair produced by the motion-control state machine and turns it into left and right motor PWM waveforms. Commands are mixed into saturated per-wheel duties and latched only on PWM period boundaries, so the outputs are glitch-free. A period-start strobe and saturation flags report back to the control side.

---
 rtl/motion_pkg.sv | 29 ++
 rtl/drive_mixer.sv | 35 +++
 rtl/motor_pwm_driver.sv | 132 +++++++++++++
 tb/tb_motor_pwm_driver.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// Shared motion-path definitions: field widths, PWM step count, straight-ahead
// direction code, motor state enum and the duty saturation helper.
package motion_pkg;

    localparam int unsigned SPEED_W            = 4;
    localparam int unsigned DIR_W              = 4;
    localparam int unsigned PWM_STEPS          = 15;
    localparam int unsigned CENTER_DIR_DEFAULT = 8;
    localparam int unsigned MIX_W              = 6;

    typedef enum logic {
        IDLE,
        RUN
    } motor_state_t;

    // Clip a signed mix result into a duty; MSB of the result is the clip flag.
    function automatic logic [SPEED_W:0] sat_duty(input logic signed [MIX_W-1:0] raw);
        logic [SPEED_W:0] res;
        if (raw < 0) begin
            res = {1'b1, {SPEED_W{1'b0}}};
        end else if (raw > MIX_W'($signed(PWM_STEPS))) begin
            res = {1'b1, {SPEED_W{1'b1}}};
        end else begin
            res = {1'b0, raw[SPEED_W-1:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/drive_mixer.sv
// Differential mixer: steers speed by the signed direction offset into
// saturated left/right duties plus per-wheel clip flags. Purely combinational.
module drive_mixer
    import motion_pkg::*;
#(
    parameter int unsigned CENTER_DIR = CENTER_DIR_DEFAULT
) (
    input  logic [SPEED_W-1:0] speed,
    input  logic [DIR_W-1:0]   dir,
    output logic [SPEED_W-1:0] duty_l,
    output logic [SPEED_W-1:0] duty_r,
    output logic               sat_l,
    output logic               sat_r
);

    logic signed [MIX_W-1:0] off;
    logic signed [MIX_W-1:0] raw_l;
    logic signed [MIX_W-1:0] raw_r;
    logic [SPEED_W:0]        res_l;
    logic [SPEED_W:0]        res_r;

    always_comb begin
        off   = $signed({{(MIX_W-DIR_W){1'b0}}, dir}) - $signed(MIX_W'(CENTER_DIR));
        raw_l = $signed({{(MIX_W-SPEED_W){1'b0}}, speed}) + off;
        raw_r = $signed({{(MIX_W-SPEED_W){1'b0}}, speed}) - off;
        res_l = sat_duty(raw_l);
        res_r = sat_duty(raw_r);
    end

    assign duty_l = res_l[SPEED_W-1:0];
    assign sat_l  = res_l[SPEED_W];
    assign duty_r = res_r[SPEED_W-1:0];
    assign sat_r  = res_r[SPEED_W];

endmodule

// File: rtl/motor_pwm_driver.sv
// Left/right motor PWM generator. Duties are latched from the mixer only on
// enable and on period wrap, so each PWM period is glitch-free.
module motor_pwm_driver
    import motion_pkg::*;
#(
    parameter int unsigned PRESCALE   = 4,
    parameter int unsigned CENTER_DIR = CENTER_DIR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [SPEED_W-1:0] speed_i,
    input  logic [DIR_W-1:0]   dir_i,
    output logic               pwm_l,
    output logic               pwm_r,
    output logic               period_start,
    output logic               sat_l,
    output logic               sat_r
);

    localparam int unsigned     PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [3:0]       CNT_MAX = 4'(PWM_STEPS - 1);

    logic [SPEED_W-1:0] mix_duty_l, mix_duty_r;
    logic               mix_sat_l, mix_sat_r;

    drive_mixer #(
        .CENTER_DIR(CENTER_DIR)
    ) u_mixer (
        .speed (speed_i),
        .dir   (dir_i),
        .duty_l(mix_duty_l),
        .duty_r(mix_duty_r),
        .sat_l (mix_sat_l),
        .sat_r (mix_sat_r)
    );

    motor_state_t       state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [SPEED_W-1:0] duty_l_q, duty_l_d, duty_r_q, duty_r_d;
    logic               sat_l_q, sat_l_d, sat_r_q, sat_r_d;
    logic               pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
    logic               ps_q, ps_d;
    logic               load;

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        duty_l_d = duty_l_q;
        duty_r_d = duty_r_q;
        sat_l_d  = sat_l_q;
        sat_r_d  = sat_r_q;
        load     = 1'b0;

        unique case (state_q)
            IDLE: begin
                pre_d = '0;
                cnt_d = '0;
                if (en) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                // Disable takes priority over a coincident period wrap.
                if (!en) begin
                    state_d = IDLE;
                    pre_d   = '0;
                    cnt_d   = '0;
                end else if (pre_q == PRE_MAX) begin
                    pre_d = '0;
                    if (cnt_q == CNT_MAX) begin
                        cnt_d = '0;
                        load  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
        endcase

        if (load) begin
            duty_l_d = mix_duty_l;
            duty_r_d = mix_duty_r;
            sat_l_d  = mix_sat_l;
            sat_r_d  = mix_sat_r;
        end

        // Outputs are registered from next-state so they line up with the counters.
        pwm_l_d = (state_d == RUN) && (cnt_d < duty_l_d);
        pwm_r_d = (state_d == RUN) && (cnt_d < duty_r_d);
        ps_d    = (state_d == RUN) && (cnt_d == '0) && (pre_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            cnt_q    <= '0;
            duty_l_q <= '0;
            duty_r_q <= '0;
            sat_l_q  <= 1'b0;
            sat_r_q  <= 1'b0;
            pwm_l_q  <= 1'b0;
            pwm_r_q  <= 1'b0;
            ps_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            duty_l_q <= duty_l_d;
            duty_r_q <= duty_r_d;
            sat_l_q  <= sat_l_d;
            sat_r_q  <= sat_r_d;
            pwm_l_q  <= pwm_l_d;
            pwm_r_q  <= pwm_r_d;
            ps_q     <= ps_d;
        end
    end

    assign pwm_l        = pwm_l_q;
    assign pwm_r        = pwm_r_q;
    assign period_start = ps_q;
    assign sat_l        = sat_l_q;
    assign sat_r        = sat_r_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver with PRESCALE=2 (30-clock period): a
// phase-counter model checked every cycle plus hand-computed period counts.
module tb_motor_pwm_driver;

    localparam int P      = 2;
    localparam int PERIOD = 15 * P;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] speed_i = 4'd0;
    logic [3:0] dir_i = 4'd8;
    logic       pwm_l, pwm_r, period_start, sat_l, sat_r;

    int vectors = 0;
    int miscompares = 0;

    motor_pwm_driver #(
        .PRESCALE  (P),
        .CENTER_DIR(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .speed_i     (speed_i),
        .dir_i       (dir_i),
        .pwm_l       (pwm_l),
        .pwm_r       (pwm_r),
        .period_start(period_start),
        .sat_l       (sat_l),
        .sat_r       (sat_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            if (miscompares <= 40) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: a single phase index within the period plus the latched command.
    bit m_run = 0;
    int m_t = 0;
    int m_dl = 0, m_dr = 0;
    bit m_sl = 0, m_sr = 0;

    function automatic int clip(input int v);
        return (v < 0) ? 0 : (v > 15) ? 15 : v;
    endfunction

    task automatic m_latch();
        int off, rl, rr;
        off  = int'(dir_i) - 8;
        rl   = int'(speed_i) + off;
        rr   = int'(speed_i) - off;
        m_dl = clip(rl);
        m_dr = clip(rr);
        m_sl = (rl < 0) || (rl > 15);
        m_sr = (rr < 0) || (rr > 15);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_t = 0; m_dl = 0; m_dr = 0; m_sl = 0; m_sr = 0;
        end else if (!en) begin
            m_run = 0;
        end else if (!m_run) begin
            m_run = 1;
            m_t   = 0;
            m_latch();
        end else begin
            m_t = (m_t + 1) % PERIOD;
            if (m_t == 0) m_latch();
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_pwm_l", int'(pwm_l), int'(m_run && (m_t < m_dl * P)));
            chk("model_pwm_r", int'(pwm_r), int'(m_run && (m_t < m_dr * P)));
            chk("model_period_start", int'(period_start), int'(m_run && (m_t == 0)));
            chk("model_sat_l", int'(sat_l), int'(m_sl));
            chk("model_sat_r", int'(sat_r), int'(m_sr));
        end
    end

    task automatic wait_ps(input string nm, output bit found);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (period_start) begin
                found = 1;
                break;
            end
        end
        if (!found) chk({nm, "_ps_timeout"}, 0, 1);
    endtask

    // Count high clocks over one period beginning at the next period_start.
    task automatic measure(input string nm, input int exp_l, input int exp_r,
                           input int chg_at, input logic [3:0] chg_speed);
        int cl, cr, cps;
        bit found;
        wait_ps(nm, found);
        if (found) begin
            cl = 0; cr = 0; cps = 0;
            for (int i = 0; i < PERIOD; i++) begin
                if (i > 0) @(negedge clk);
                cl  += int'(pwm_l);
                cr  += int'(pwm_r);
                cps += int'(period_start);
                if (i == chg_at) speed_i = chg_speed;
            end
            chk({nm, "_hi_l"}, cl, exp_l);
            chk({nm, "_hi_r"}, cr, exp_r);
            chk({nm, "_ps_count"}, cps, 1);
        end
    endtask

    initial begin
        bit found;
        repeat (2) @(negedge clk);
        chk("reset_pwm_l", int'(pwm_l), 0);
        chk("reset_pwm_r", int'(pwm_r), 0);
        chk("reset_ps", int'(period_start), 0);
        chk("reset_sat", int'({sat_l, sat_r}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Straight drive.
        speed_i = 4'd5; dir_i = 4'd8; en = 1'b1;
        measure("straight", 10, 10, -1, 4'd0);
        chk("straight_sat", int'({sat_l, sat_r}), 0);

        // Right steer, left wheel clipped high.
        speed_i = 4'd12; dir_i = 4'd12;
        measure("right_sat", 30, 16, -1, 4'd0);
        chk("right_sat_l", int'(sat_l), 1);
        chk("right_sat_r", int'(sat_r), 0);

        // Hard left at low speed, left wheel clipped low.
        speed_i = 4'd3; dir_i = 4'd0;
        measure("hard_left", 0, 22, -1, 4'd0);
        chk("hard_left_sat_l", int'(sat_l), 1);
        chk("hard_left_sat_r", int'(sat_r), 0);

        // Mid-period change at clock 7 must not disturb the current period.
        speed_i = 4'd5; dir_i = 4'd8;
        measure("mid_chg_cur", 10, 10, 7, 4'd15);
        measure("mid_chg_next", 30, 30, -1, 4'd0);

        // Enable drop at clock 4, then re-enable with a new command.
        wait_ps("en_drop", found);
        repeat (4) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_drop_pwm", int'({pwm_l, pwm_r}), 0);
        chk("en_drop_ps", int'(period_start), 0);
        chk("en_drop_sat_hold", int'({sat_l, sat_r}), 0);
        speed_i = 4'd3; dir_i = 4'd0; en = 1'b1;
        @(negedge clk);
        chk("reen_ps", int'(period_start), 1);
        chk("reen_pwm", int'({pwm_l, pwm_r}), 1);
        chk("reen_sat_l", int'(sat_l), 1);
        measure("reen_period", 0, 22, -1, 4'd0);

        // Asynchronous reset at clock 12 of a period.
        speed_i = 4'd5; dir_i = 4'd8;
        wait_ps("rst_mid", found);
        repeat (12) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_out", int'({pwm_l, pwm_r, period_start, sat_l, sat_r}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ps", int'(period_start), 1);
        measure("rst_release_period", 10, 10, -1, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
